program_rom_loader: RTL and testbench
=====================================

# program_rom_loader

Writer-side front end for the 20-bit instruction ROM (`COMMAND_REGISTER`). It receives a program as a byte stream over a valid/ready handshake and assembles each group of three bytes into one 20-bit instruction word. Each word is written to consecutive ROM addresses starting at 0. When the load is finished it raises `done_loading`, and the control unit uses that signal to begin fetching from PC 0.

## Interface
- `ADDR_W`, default 10: ROM address width; capacity is 2**ADDR_W words.
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: one-cycle pulse that arms a new load.
- `byte_in`, in, 8: incoming program byte.
- `byte_valid`, in, 1: `byte_in` is valid.
- `byte_ready`, out, 1: loader can accept a byte this cycle.
- `rom_addr`, out, ADDR_W: ROM write address.
- `rom_data`, out, 20: ROM write word (matches the ROM `in_word` port).
- `rom_en`, out, 1: ROM enable (`memoryEN`); high only during a write cycle.
- `rom_rw`, out, 1: ROM direction; 0 = write, 1 = read.
- `done_loading`, out, 1: program fully written; ROM may be read.
- `error`, out, 1: sticky framing error.
- `word_count`, out, ADDR_W+1: number of words written.

## Operation
- **Word format:** 3 bytes per word, most significant byte first.
  - b0[3:0] → word[19:16].
  - b1 → word[15:8].
  - b2 → word[7:0].
  - b0[7:4] must be 0; a nonzero value is a framing error.
- **Handshake:** a byte transfers on a rising edge with `byte_valid && byte_ready`. `byte_ready` is high only in states B0, B1 and B2.
- **States:**
  - IDLE: `byte_ready` = 0. `start` → B0, clearing `word_count`, `done_loading` and `error`.
  - B0: on accept with b0[7:4] ≠ 0 → ERR. Otherwise latch the opcode nibble → B1.
  - B1: on accept, latch the byte → B2.
  - B2: on accept, assemble the word.
    - Word == 20'h00000 (terminator) → DONE. The terminator is not written.
    - Otherwise drive `rom_addr` = `word_count` and `rom_data` = word → WRITE.
  - WRITE (exactly 1 cycle): `rom_en` = 1, `rom_rw` = 0, address and data stable. At exit, `word_count` increments.
    - If the new `word_count` == 2**ADDR_W → DONE.
    - Otherwise → B0.
  - DONE: `done_loading` = 1, `byte_ready` = 0. `start` → B0 with clear, as from IDLE.
  - ERR: `error` = 1, `done_loading` = 0, `byte_ready` = 0. Only `start` or reset leaves this state.
- `start` is ignored in B0, B1, B2 and WRITE.
- Outside WRITE: `rom_en` = 0 and `rom_rw` = 1, so the ROM is in read mode for the control unit. `rom_addr` and `rom_data` hold their last values.
- `word_count` saturates at 2**ADDR_W, which is why it is ADDR_W+1 bits wide.

## Timing
- **Reset values:** state IDLE, `byte_ready` 0, `rom_addr` 0, `rom_data` 0, `rom_en` 0, `rom_rw` 1, `done_loading` 0, `error` 0, `word_count` 0.
- **Reset mid-load:** asynchronous. All outputs go to their reset values immediately. A partially assembled word is discarded and no ROM write occurs.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Write latency:** b2 accepted at edge N.
  - `rom_en` is high from edge N to edge N+1.
  - `word_count` increments at edge N+1.
  - `byte_ready` is high again after edge N+1.
  - Peak rate is therefore 1 word per 4 cycles.
- **Terminator:** `done_loading` rises at the edge that accepts the terminator's third byte.
- **Framing error:** `error` rises at the edge that accepts the bad b0.
- **Capacity fill:** when the write to address 2**ADDR_W−1 completes, `done_loading` rises at the WRITE exit edge. No terminator is needed.
- `byte_valid` may drop between bytes; the loader holds its state indefinitely.

## Test plan
- **Basic load:** reset, pulse `start`, send 07 05 03 | 0F 03 00 | 00 00 00. Expect exactly 2 writes:
  - addr 0 = 20'h70503, addr 1 = 20'hF0300.
  - `word_count` = 2, `done_loading` = 1, `byte_ready` = 0.
- **Backpressure and gaps:** toggle `byte_valid` randomly during the stream. Expect the same writes; each `rom_en` pulse lasts exactly 1 cycle with `rom_rw` = 0.
- **Framing error:** send b0 = 8'h1A. Expect `error` = 1, no write, `byte_ready` = 0. Then pulse `start` and send a valid load; expect `error` cleared and a correct load.
- **Capacity fill (ADDR_W = 2):** send 4 nonzero words with no terminator. Expect writes to addresses 0–3, `word_count` = 4, and `done_loading` = 1 at the fourth WRITE exit. Extra bytes must not be accepted.
- **Reset mid-word:** assert `rst_n` = 0 after b1. Expect all outputs at reset values immediately and no write. After `start`, the next word lands at addr 0.
- **Start while loading:** pulse `start` in B1. Expect it ignored, and assembly of the current word continues unaffected.

Source files
------------

// File: rtl/program_rom_loader.sv
// Byte-stream program loader for the 20-bit instruction ROM: packs three bytes
// per word, writes words to consecutive addresses and flags completion or framing errors.
module program_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [19:0]       rom_data,
  output logic              rom_en,
  output logic              rom_rw,
  output logic              done_loading,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_B0    = 3'd1,
    ST_B1    = 3'd2,
    ST_B2    = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [19:0]     TERMINATOR = 20'h00000;

  // First byte carries only the opcode nibble; the upper nibble must be clear.
  function automatic logic framing_bad(input logic [7:0] b0);
    framing_bad = (b0[7:4] != 4'h0);
  endfunction

  function automatic logic [19:0] assemble_word(input logic [3:0] nib,
                                                input logic [7:0] mid,
                                                input logic [7:0] low);
    assemble_word = {nib, mid, low};
  endfunction

  state_t          state_r;
  logic [3:0]      nib_r;
  logic [7:0]      mid_r;

  logic            accept_s;
  logic            arm_s;
  logic [19:0]     word_s;
  logic [ADDR_W:0] next_count_s;
  logic            count_full_s;

  // Handshake qualification, word assembly and capacity look-ahead.
  always_comb begin
    accept_s     = 1'b0;
    arm_s        = 1'b0;
    word_s       = 20'h00000;
    next_count_s = word_count + {{ADDR_W{1'b0}}, 1'b1};
    count_full_s = 1'b0;
    if (byte_valid && byte_ready) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR))) begin
      arm_s = 1'b1;
    end else begin
      arm_s = 1'b0;
    end
    word_s = assemble_word(nib_r, mid_r, byte_in);
    if (next_count_s == CAPACITY) begin
      count_full_s = 1'b1;
    end else begin
      count_full_s = 1'b0;
    end
  end

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      nib_r        <= 4'h0;
      mid_r        <= 8'h00;
      byte_ready   <= 1'b0;
      rom_addr     <= {ADDR_W{1'b0}};
      rom_data     <= 20'h00000;
      rom_en       <= 1'b0;
      rom_rw       <= 1'b1;
      done_loading <= 1'b0;
      error        <= 1'b0;
      word_count   <= {(ADDR_W+1){1'b0}};
    end else if (arm_s) begin
      state_r      <= ST_B0;
      byte_ready   <= 1'b1;
      rom_en       <= 1'b0;
      rom_rw       <= 1'b1;
      done_loading <= 1'b0;
      error        <= 1'b0;
      word_count   <= {(ADDR_W+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          byte_ready <= 1'b0;
        end

        ST_B0: begin
          if (accept_s) begin
            if (framing_bad(byte_in)) begin
              state_r      <= ST_ERR;
              byte_ready   <= 1'b0;
              error        <= 1'b1;
              done_loading <= 1'b0;
            end else begin
              nib_r   <= byte_in[3:0];
              state_r <= ST_B1;
            end
          end
        end

        ST_B1: begin
          if (accept_s) begin
            mid_r   <= byte_in;
            state_r <= ST_B2;
          end
        end

        ST_B2: begin
          if (accept_s) begin
            byte_ready <= 1'b0;
            // The all-zero terminator word ends the load and is never written.
            if (word_s == TERMINATOR) begin
              state_r      <= ST_DONE;
              done_loading <= 1'b1;
            end else begin
              state_r  <= ST_WRITE;
              rom_addr <= word_count[ADDR_W-1:0];
              rom_data <= word_s;
              rom_en   <= 1'b1;
              rom_rw   <= 1'b0;
            end
          end
        end

        ST_WRITE: begin
          rom_en     <= 1'b0;
          rom_rw     <= 1'b1;
          word_count <= next_count_s;
          if (count_full_s) begin
            state_r      <= ST_DONE;
            byte_ready   <= 1'b0;
            done_loading <= 1'b1;
          end else begin
            state_r    <= ST_B0;
            byte_ready <= 1'b1;
          end
        end

        ST_DONE: begin
          byte_ready   <= 1'b0;
          done_loading <= 1'b1;
        end

        ST_ERR: begin
          byte_ready   <= 1'b0;
          done_loading <= 1'b0;
          error        <= 1'b1;
        end

        default: begin
          state_r    <= ST_IDLE;
          byte_ready <= 1'b0;
          rom_en     <= 1'b0;
          rom_rw     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_rom_loader.sv
// Directed self-checking bench for program_rom_loader, built with ADDR_W = 2.
module tb_program_rom_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [AW-1:0] rom_addr;
  logic [19:0]   rom_data;
  logic          rom_en;
  logic          rom_rw;
  logic          done_loading;
  logic          error;
  logic [AW:0]   word_count;

  int            checks = 0;
  int            failures = 0;
  int            max_gap = 0;
  logic [31:0]   wr_addr[$];
  logic [31:0]   wr_data[$];
  logic          prev_en = 1'b0;

  program_rom_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_en(rom_en), .rom_rw(rom_rw),
    .done_loading(done_loading), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write log plus per-write protocol checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_en) begin
        wr_addr.push_back(32'(rom_addr));
        wr_data.push_back(32'(rom_data));
        check_eq("write_rw", 32'(rom_rw), 32'd0);
        check_eq("en_one_cycle", 32'(prev_en), 32'd0);
      end
    end
    prev_en <= rom_en;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check_eq({p, "_ready"}, 32'(byte_ready), 32'd0);
    check_eq({p, "_addr"}, 32'(rom_addr), 32'd0);
    check_eq({p, "_data"}, 32'(rom_data), 32'd0);
    check_eq({p, "_en"}, 32'(rom_en), 32'd0);
    check_eq({p, "_rw"}, 32'(rom_rw), 32'd1);
    check_eq({p, "_done"}, 32'(done_loading), 32'd0);
    check_eq({p, "_err"}, 32'(error), 32'd0);
    check_eq({p, "_wc"}, 32'(word_count), 32'd0);
  endtask

  task automatic basic_load(input string p);
    clear_log();
    pulse_start();
    check_eq({p, "_armed_ready"}, 32'(byte_ready), 32'd1);
    send_word(8'h07, 8'h05, 8'h03);
    send_word(8'h0F, 8'h03, 8'h00);
    send_word(8'h00, 8'h00, 8'h00);
    check_eq({p, "_done"}, 32'(done_loading), 32'd1);
    check_eq({p, "_wc"}, 32'(word_count), 32'd2);
    check_eq({p, "_ready"}, 32'(byte_ready), 32'd0);
    check_eq({p, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    check_eq({p, "_a0"}, wr_addr[0], 32'd0);
    check_eq({p, "_d0"}, wr_data[0], 32'h70503);
    check_eq({p, "_a1"}, wr_addr[1], 32'd1);
    check_eq({p, "_d1"}, wr_data[1], 32'hF0300);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_ready", 32'(byte_ready), 32'd0);

    basic_load("basic");

    max_gap = 3;
    basic_load("gaps");
    max_gap = 0;

    // Framing error, then recovery through start.
    clear_log();
    pulse_start();
    send_byte(8'h1A);
    check_eq("frm_err", 32'(error), 32'd1);
    check_eq("frm_ready", 32'(byte_ready), 32'd0);
    check_eq("frm_done", 32'(done_loading), 32'd0);
    @(negedge clk);
    byte_in = 8'h02;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check_eq("frm_err_sticky", 32'(error), 32'd1);
    check_eq("frm_nwr", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    check_eq("frm_err_clr", 32'(error), 32'd0);
    check_eq("frm_rearm_ready", 32'(byte_ready), 32'd1);
    send_word(8'h02, 8'h34, 8'h56);
    send_word(8'h00, 8'h00, 8'h00);
    check_eq("frm_reload_done", 32'(done_loading), 32'd1);
    check_eq("frm_reload_wc", 32'(word_count), 32'd1);
    check_eq("frm_reload_nwr", 32'(wr_addr.size()), 32'd1);
    check_eq("frm_reload_d0", wr_data[0], 32'h23456);

    // Capacity fill without terminator.
    clear_log();
    pulse_start();
    send_word(8'h01, 8'h00, 8'h01);
    send_word(8'h02, 8'h00, 8'h02);
    send_word(8'h03, 8'h00, 8'h03);
    send_word(8'h04, 8'h00, 8'h04);
    check_eq("cap_en_last", 32'(rom_en), 32'd1);
    check_eq("cap_done_early", 32'(done_loading), 32'd0);
    @(posedge clk);
    #1;
    check_eq("cap_done", 32'(done_loading), 32'd1);
    check_eq("cap_wc", 32'(word_count), 32'd4);
    check_eq("cap_en_off", 32'(rom_en), 32'd0);
    @(negedge clk);
    byte_in = 8'h55;
    byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("cap_no_accept", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    check_eq("cap_nwr", 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("cap_addr", wr_addr[i], 32'(i));
      check_eq("cap_data", wr_data[i], 32'h10001 * 32'(i + 1));
    end

    // Reset in the middle of a word.
    clear_log();
    pulse_start();
    send_byte(8'h09);
    send_byte(8'h08);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_nwr", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    send_word(8'h01, 8'h02, 8'h03);
    send_word(8'h00, 8'h00, 8'h00);
    check_eq("midrst_nwr2", 32'(wr_addr.size()), 32'd1);
    check_eq("midrst_a0", wr_addr[0], 32'd0);
    check_eq("midrst_d0", wr_data[0], 32'h10203);

    // Start pulse while in B1 must be ignored.
    clear_log();
    pulse_start();
    send_word(8'h01, 8'h11, 8'h22);
    send_byte(8'h05);
    pulse_start();
    check_eq("st_b1_ready", 32'(byte_ready), 32'd1);
    check_eq("st_b1_wc", 32'(word_count), 32'd1);
    send_byte(8'h06);
    send_byte(8'h07);
    send_word(8'h00, 8'h00, 8'h00);
    check_eq("st_nwr", 32'(wr_addr.size()), 32'd2);
    check_eq("st_d0", wr_data[0], 32'h11122);
    check_eq("st_a1", wr_addr[1], 32'd1);
    check_eq("st_d1", wr_data[1], 32'h50607);
    check_eq("st_wc", 32'(word_count), 32'd2);
    check_eq("st_done", 32'(done_loading), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
